// File: rtl/hud_counter.sv
// -----------------------------------------------------------------------------
// hud_counter
//
// Game HUD counter feeding the six HexDriver instances on HEX5..HEX0.
//   Digits 5..3 : BCD countdown timer, decremented every TICK_FRAMES frames.
//   Digits 2..0 : BCD score, incremented by KILL_POINTS per goomba kill and
//                 saturating at 999.
// A three-state game machine (RUN / DEAD / TIMEUP) freezes or reloads both
// fields and reports time-out back to the player logic.
//
// Ports
//   Clk            in   1   system clock (50 MHz)
//   Reset_n        in   1   asynchronous active-low reset
//   frame_clk      in   1   VGA vertical sync, asynchronous to Clk
//   mario_dead     in   1   death level from the collision block (Clk domain)
//   gomba_dead     in   1   kill level from the collision block; one kill per
//                           rising edge
//   restart        in   1   one-Clk pulse requesting a new round
//   mario_counter  out  24  {timer[11:0], score[11:0]}, BCD digits
//   time_up        out  1   high while the game state is TIMEUP
//   game_state     out  2   00 RUN, 01 DEAD, 10 TIMEUP
//
// Parameters
//   TIME_START   timer reload value, 3 BCD digits (each nibble 0-9)
//   TICK_FRAMES  frame ticks per timer decrement (1..255)
//   KILL_POINTS  BCD points added per kill (1..9)
// -----------------------------------------------------------------------------
module hud_counter #(
    parameter logic [11:0] TIME_START  = 12'h400,
    parameter int unsigned TICK_FRAMES = 24,
    parameter logic [3:0]  KILL_POINTS = 4'd1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        mario_dead,
    input  logic        gomba_dead,
    input  logic        restart,
    output logic [23:0] mario_counter,
    output logic        time_up,
    output logic [1:0]  game_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DEAD   = 2'b01,
        ST_TIMEUP = 2'b10
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(TICK_FRAMES - 1);

    // -------------------------------------------------------------------------
    // BCD helpers
    // -------------------------------------------------------------------------

    // Adds a single BCD digit to a 3-digit BCD value; bit 12 of the result is
    // the carry out of the hundreds digit (true sum above 999).
    function automatic logic [12:0] bcd_add(input logic [11:0] value,
                                            input logic [3:0]  addend);
        logic [4:0]  sum;
        logic [11:0] res;
        logic        carry;
        res   = '0;
        carry = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sum = {1'b0, value[4*i +: 4]} + {4'd0, carry};
            if (i == 0) begin
                sum = sum + {1'b0, addend};
            end
            if (sum > 5'd9) begin
                res[4*i +: 4] = 4'(sum - 5'd10);
                carry         = 1'b1;
            end else begin
                res[4*i +: 4] = sum[3:0];
                carry         = 1'b0;
            end
        end
        return {carry, res};
    endfunction

    // Subtracts one from a 3-digit BCD value; a zero digit that has to borrow
    // becomes 9 and passes the borrow upward.
    function automatic logic [11:0] bcd_dec(input logic [11:0] value);
        logic [11:0] res;
        logic [3:0]  digit;
        logic        borrow;
        res    = '0;
        borrow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            digit = value[4*i +: 4];
            if (!borrow) begin
                res[4*i +: 4] = digit;
            end else if (digit == 4'd0) begin
                res[4*i +: 4] = 4'd9;
            end else begin
                res[4*i +: 4] = digit - 4'd1;
                borrow        = 1'b0;
            end
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Input conditioning
    // -------------------------------------------------------------------------
    logic frame_sync1;
    logic frame_sync2;
    logic frame_prev;
    logic gomba_prev;
    logic tick;
    logic kill;

    // All four flops come out of reset high so that a frame_clk or gomba_dead
    // level already high at reset release does not look like a rising edge.
    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples the pre-edge value of the others; blocking here would collapse
    // the synchroniser chain into a single stage.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sync1 <= 1'b1;
            frame_sync2 <= 1'b1;
            frame_prev  <= 1'b1;
            gomba_prev  <= 1'b1;
        end else begin
            frame_sync1 <= frame_clk;
            frame_sync2 <= frame_sync1;
            frame_prev  <= frame_sync2;
            gomba_prev  <= gomba_dead;
        end
    end

    assign tick = frame_sync2 & ~frame_prev;
    assign kill = gomba_dead & ~gomba_prev;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t      state;
    state_t      state_next;
    logic [11:0] timer;
    logic [11:0] timer_next;
    logic [11:0] score;
    logic [11:0] score_next;
    logic [7:0]  frame_cnt;
    logic [7:0]  frame_cnt_next;
    logic        time_up_next;

    // Shared decisions used by both the next-state and datapath logic.
    logic        run_tick;
    logic        dec_event;
    logic [11:0] timer_dec;
    logic [12:0] score_sum;

    // A death in the same cycle as a tick wins: the tick is dropped entirely.
    assign run_tick  = (state == ST_RUN) && tick && !mario_dead;
    assign dec_event = run_tick && (frame_cnt == TICK_LAST) && (timer != 12'h000);
    assign timer_dec = bcd_dec(timer);
    assign score_sum = bcd_add(score, KILL_POINTS);

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    // NOTE: every variable written in an always_comb gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (mario_dead) begin
                    state_next = ST_DEAD;
                end else if (dec_event && (timer_dec == 12'h000)) begin
                    state_next = ST_TIMEUP;
                end
            end
            ST_DEAD, ST_TIMEUP: begin
                if (restart) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Output logic: time_up is registered alongside the state so it rises in
    // the same cycle the timer first shows 000.
    always_comb begin
        time_up_next = (state_next == ST_TIMEUP);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            time_up <= 1'b0;
        end else begin
            time_up <= time_up_next;
        end
    end

    // Datapath next values
    always_comb begin
        timer_next     = timer;
        score_next     = score;
        frame_cnt_next = frame_cnt;
        case (state)
            ST_RUN: begin
                // The kill is scored even when mario_dead arrives in the same
                // cycle, since the current state is still RUN.
                if (kill) begin
                    score_next = score_sum[12] ? 12'h999 : score_sum[11:0];
                end
                if (run_tick) begin
                    if (frame_cnt == TICK_LAST) begin
                        frame_cnt_next = 8'd0;
                        if (dec_event) begin
                            timer_next = timer_dec;
                        end
                    end else begin
                        frame_cnt_next = frame_cnt + 8'd1;
                    end
                end
            end
            ST_DEAD, ST_TIMEUP: begin
                // Restart overrides any tick or kill arriving with it.
                if (restart) begin
                    timer_next     = TIME_START;
                    score_next     = 12'h000;
                    frame_cnt_next = 8'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            timer     <= TIME_START;
            score     <= 12'h000;
            frame_cnt <= 8'd0;
        end else begin
            timer     <= timer_next;
            score     <= score_next;
            frame_cnt <= frame_cnt_next;
        end
    end

    assign mario_counter = {timer, score};
    assign game_state    = state;

endmodule

// File: tb/tb_hud_counter.sv
// -----------------------------------------------------------------------------
// tb_hud_counter
//
// Directed bench for hud_counter. Five instances with different parameter
// sets run side by side, each with its own input vector bit:
//   0 : defaults (400, 24, 1)  reset, simultaneous death, saturation
//   1 : (101, 2, 1)            multi-digit borrow, frame rollover
//   2 : (002, 1, 1)            time-out, hold at 000, restart
//   3 : (400, 1, 1)            asynchronous reset mid-round
//   4 : (400, 24, 5)           decimal carry and saturation with 5 points
// -----------------------------------------------------------------------------
module tb_hud_counter;

    logic        clk;
    logic [4:0]  rst_n;
    logic [4:0]  frame;
    logic [4:0]  mdead;
    logic [4:0]  gdead;
    logic [4:0]  rstrt;
    logic [23:0] counter [5];
    logic [4:0]  tup;
    logic [1:0]  gstate [5];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hud_counter #(.TIME_START(12'h400), .TICK_FRAMES(24), .KILL_POINTS(4'd1)) u0 (
        .Clk(clk), .Reset_n(rst_n[0]), .frame_clk(frame[0]), .mario_dead(mdead[0]),
        .gomba_dead(gdead[0]), .restart(rstrt[0]), .mario_counter(counter[0]),
        .time_up(tup[0]), .game_state(gstate[0]));

    hud_counter #(.TIME_START(12'h101), .TICK_FRAMES(2), .KILL_POINTS(4'd1)) u1 (
        .Clk(clk), .Reset_n(rst_n[1]), .frame_clk(frame[1]), .mario_dead(mdead[1]),
        .gomba_dead(gdead[1]), .restart(rstrt[1]), .mario_counter(counter[1]),
        .time_up(tup[1]), .game_state(gstate[1]));

    hud_counter #(.TIME_START(12'h002), .TICK_FRAMES(1), .KILL_POINTS(4'd1)) u2 (
        .Clk(clk), .Reset_n(rst_n[2]), .frame_clk(frame[2]), .mario_dead(mdead[2]),
        .gomba_dead(gdead[2]), .restart(rstrt[2]), .mario_counter(counter[2]),
        .time_up(tup[2]), .game_state(gstate[2]));

    hud_counter #(.TIME_START(12'h400), .TICK_FRAMES(1), .KILL_POINTS(4'd1)) u3 (
        .Clk(clk), .Reset_n(rst_n[3]), .frame_clk(frame[3]), .mario_dead(mdead[3]),
        .gomba_dead(gdead[3]), .restart(rstrt[3]), .mario_counter(counter[3]),
        .time_up(tup[3]), .game_state(gstate[3]));

    hud_counter #(.TIME_START(12'h400), .TICK_FRAMES(24), .KILL_POINTS(4'd5)) u4 (
        .Clk(clk), .Reset_n(rst_n[4]), .frame_clk(frame[4]), .mario_dead(mdead[4]),
        .gomba_dead(gdead[4]), .restart(rstrt[4]), .mario_counter(counter[4]),
        .time_up(tup[4]), .game_state(gstate[4]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One full frame_clk period; leaves frame_clk high with the tick consumed.
    task automatic frame_edge(input int i);
        frame[i] = 1'b0;
        cycles(4);
        frame[i] = 1'b1;
        cycles(5);
    endtask

    task automatic kill(input int i);
        gdead[i] = 1'b1;
        cycles(2);
        gdead[i] = 1'b0;
        cycles(2);
    endtask

    task automatic pulse_restart(input int i);
        rstrt[i] = 1'b1;
        cycles(1);
        rstrt[i] = 1'b0;
        cycles(1);
    endtask

    initial begin
        rst_n = '0;
        frame = '1;
        mdead = '0;
        gdead = '1;
        rstrt = '0;
        cycles(3);

        // Values under reset
        check("rst_cnt0", counter[0], 24'h400000);
        check("rst_cnt1", counter[1], 24'h101000);
        check("rst_cnt2", counter[2], 24'h002000);
        check("rst_state0", gstate[0], 2'b00);
        check("rst_tup0", tup[0], 1'b0);

        // Release with frame_clk and gomba_dead held high: nothing counted
        rst_n = '1;
        cycles(100);
        check("hold_cnt0", counter[0], 24'h400000);
        check("hold_state0", gstate[0], 2'b00);
        check("hold_cnt4", counter[4], 24'h400000);
        gdead = '0;
        cycles(2);
        check("fall_cnt0", counter[0], 24'h400000);

        // ---- Instance 1: 101 -> 101 -> 100 -> 100 -> 099 ----
        frame_edge(1);
        check("b_edge1", counter[1], 24'h101000);
        frame_edge(1);
        check("b_edge2", counter[1], 24'h100000);
        frame_edge(1);
        check("b_edge3", counter[1], 24'h100000);
        frame_edge(1);
        check("b_edge4", counter[1], 24'h099000);

        // ---- Instance 2: time-out ----
        frame_edge(2);
        check("c_edge1", counter[2], 24'h001000);
        check("c_tup1", tup[2], 1'b0);
        frame_edge(2);
        check("c_edge2", counter[2], 24'h000000);
        check("c_tup2", tup[2], 1'b1);
        check("c_state2", gstate[2], 2'b10);
        for (int k = 0; k < 5; k++) begin
            frame_edge(2);
            check("c_hold", counter[2], 24'h000000);
        end
        kill(2);
        check("c_kill_ignored", counter[2], 24'h000000);
        check("c_state_hold", gstate[2], 2'b10);
        // restart together with a kill: restart wins, score stays 000
        gdead[2] = 1'b1;
        rstrt[2] = 1'b1;
        cycles(1);
        rstrt[2] = 1'b0;
        gdead[2] = 1'b0;
        cycles(1);
        check("c_restart", counter[2], 24'h002000);
        check("c_restart_tup", tup[2], 1'b0);
        check("c_restart_state", gstate[2], 2'b00);

        // ---- Instance 0: death, tick and kill in the same cycle ----
        for (int k = 0; k < 23; k++) frame_edge(0);
        check("a_pre23", counter[0], 24'h400000);
        frame[0] = 1'b0;
        cycles(4);
        frame[0] = 1'b1;
        cycles(2);            // tick is now pending for the next edge
        mdead[0] = 1'b1;
        gdead[0] = 1'b1;
        cycles(1);
        gdead[0] = 1'b0;
        check("a_sim_cnt", counter[0], 24'h400001);
        check("a_sim_state", gstate[0], 2'b01);
        check("a_sim_tup", tup[0], 1'b0);
        frame_edge(0);
        frame_edge(0);
        kill(0);
        check("a_dead_hold", counter[0], 24'h400001);
        check("a_dead_state", gstate[0], 2'b01);
        mdead[0] = 1'b0;
        cycles(1);
        pulse_restart(0);
        check("a_restart", counter[0], 24'h400000);
        check("a_restart_state", gstate[0], 2'b00);
        // restart in RUN is ignored
        kill(0);
        pulse_restart(0);
        check("a_run_restart", counter[0], 24'h400001);

        // Saturation: 997 more kills reach 998, then three more stick at 999
        for (int k = 0; k < 997; k++) kill(0);
        check("a_998", counter[0], 24'h400998);
        kill(0);
        check("a_sat1", counter[0], 24'h400999);
        kill(0);
        check("a_sat2", counter[0], 24'h400999);
        kill(0);
        check("a_sat3", counter[0], 24'h400999);

        // ---- Instance 4: five points per kill ----
        kill(4);
        check("e_005", counter[4], 24'h400005);
        kill(4);
        check("e_010", counter[4], 24'h400010);
        kill(4);
        check("e_015", counter[4], 24'h400015);
        for (int k = 0; k < 196; k++) kill(4);
        check("e_995", counter[4], 24'h400995);
        kill(4);
        check("e_sat1", counter[4], 24'h400999);
        kill(4);
        check("e_sat2", counter[4], 24'h400999);

        // ---- Instance 3: asynchronous reset mid-round ----
        for (int k = 0; k < 150; k++) frame_edge(3);
        for (int k = 0; k < 17; k++) kill(3);
        check("d_mid", counter[3], 24'h250017);
        check("d_mid_state", gstate[3], 2'b00);
        rst_n[3] = 1'b0;      // at the falling clock edge, 5 ns before a rising edge
        #1;
        check("d_async_cnt", counter[3], 24'h400000);
        check("d_async_state", gstate[3], 2'b00);
        check("d_async_tup", tup[3], 1'b0);
        cycles(2);
        rst_n[3] = 1'b1;
        cycles(2);
        check("d_after", counter[3], 24'h400000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
